// File: rtl/div_pkg.sv
// rtl/div_pkg.sv - shared state encoding and constants for the sequential divider
package div_pkg;

    // Default operand/result width used when the divider is not overridden.
    localparam int DIV_DEFAULT_WIDTH = 16;

    // Controller states; FIXUP is only reachable when signed support is built in.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CALC  = 2'd1,
        FIXUP = 2'd2,
        DONE  = 2'd3
    } div_state_e;

    // All-ones quotient reported on divide-by-zero, for widths of 1 to 64 bits.
    function automatic logic [63:0] DZ_QUOTIENT(input int width);
        logic [63:0] ones;
        ones = '1;
        if (width >= 64) begin
            return ones;
        end
        return ones >> (64 - width);
    endfunction

endpackage

// File: rtl/div_step.sv
// rtl/div_step.sv - one restoring shift-subtract iteration, purely combinational
module div_step
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_DEFAULT_WIDTH
) (
    input  logic [WIDTH:0]   r,
    input  logic [WIDTH-1:0] q,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH:0]   r_next,
    output logic [WIDTH-1:0] q_next
);

    logic [WIDTH:0] r_shift;
    logic [WIDTH:0] trial;
    logic           fits;

    // Shift the next dividend bit into R and keep the subtraction only if it did not borrow.
    // A set top bit of R means the shifted value already exceeds any divisor, so it always fits.
    always_comb begin
        r_shift = {r[WIDTH-1:0], q[WIDTH-1]};
        trial   = r_shift - {1'b0, d};
        fits    = ~trial[WIDTH] | r[WIDTH];
        r_next  = fits ? trial : r_shift;
        q_next  = {q[WIDTH-2:0], fits};
    end

endmodule

// File: rtl/div_seq_param.sv
// rtl/div_seq_param.sv - sequential restoring divider with valid/ready handshakes (option: DIV_SIGNED_EN)
module div_seq_param
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_DEFAULT_WIDTH
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
`ifdef DIV_SIGNED_EN
    input  logic             is_signed,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             dz,
    output logic             busy
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [WIDTH-1:0] DZ_Q = WIDTH'(DZ_QUOTIENT(WIDTH));

    div_state_e       state;
    div_state_e       state_next;
    logic [WIDTH-1:0] q_reg;
    logic [WIDTH:0]   r_reg;
    logic [WIDTH-1:0] d_reg;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] step_q;
    logic [WIDTH:0]   step_r;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic             accept;
    logic             last_iter;

    assign accept    = in_valid & in_ready;
    assign last_iter = (cnt == CNT_W'(1));

`ifdef DIV_SIGNED_EN
    logic a_neg;
    logic b_neg;
    logic neg_q;
    logic neg_r;

    // Signed operands are divided as magnitudes; the signs are reapplied in FIXUP.
    assign a_neg = is_signed & dividend[WIDTH-1];
    assign b_neg = is_signed & divisor[WIDTH-1];
    assign a_mag = a_neg ? -dividend : dividend;
    assign b_mag = b_neg ? -divisor : divisor;
`else
    assign a_mag = dividend;
    assign b_mag = divisor;
`endif

    div_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .r      (r_reg),
        .q      (q_reg),
        .d      (d_reg),
        .r_next (step_r),
        .q_next (step_q)
    );

    // State register; reset aborts any division in flight.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: fixed WIDTH iterations, divide-by-zero short-circuits to DONE.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_next = (divisor == '0) ? DONE : CALC;
                end
            end
            CALC: begin
                if (last_iter) begin
`ifdef DIV_SIGNED_EN
                    state_next = FIXUP;
`else
                    state_next = DONE;
`endif
                end
            end
            FIXUP: state_next = DONE;
            DONE: begin
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Handshake and status outputs decoded from the state.
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b1;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
            end
            DONE:    out_valid = 1'b1;
            default: ;
        endcase
    end

    // Datapath: operand capture, per-cycle iteration, and result registers that hold after handshake.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            q_reg     <= '0;
            r_reg     <= '0;
            d_reg     <= '0;
            cnt       <= '0;
            quotient  <= '0;
            remainder <= '0;
            dz        <= 1'b0;
`ifdef DIV_SIGNED_EN
            neg_q     <= 1'b0;
            neg_r     <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        q_reg <= a_mag;
                        d_reg <= b_mag;
                        r_reg <= '0;
                        cnt   <= CNT_W'(WIDTH);
`ifdef DIV_SIGNED_EN
                        neg_q <= a_neg ^ b_neg;
                        neg_r <= a_neg;
`endif
                        if (divisor == '0) begin
                            quotient  <= DZ_Q;
                            remainder <= dividend;
                            dz        <= 1'b1;
                        end
                    end
                end
                CALC: begin
                    q_reg <= step_q;
                    r_reg <= step_r;
                    cnt   <= cnt - CNT_W'(1);
`ifndef DIV_SIGNED_EN
                    if (last_iter) begin
                        quotient  <= step_q;
                        remainder <= step_r[WIDTH-1:0];
                        dz        <= 1'b0;
                    end
`endif
                end
`ifdef DIV_SIGNED_EN
                FIXUP: begin
                    quotient  <= neg_q ? -q_reg : q_reg;
                    remainder <= neg_r ? -r_reg[WIDTH-1:0] : r_reg[WIDTH-1:0];
                    dz        <= 1'b0;
                end
`endif
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_div_seq_param.sv
// tb/tb_div_seq_param.sv - self-checking bench for div_seq_param at widths 16 and 8
module tb_div_seq_param;

`ifdef DIV_SIGNED_EN
    localparam int SIGNED_BUILD = 1;
`else
    localparam int SIGNED_BUILD = 0;
`endif

    logic clock = 1'b0;
    logic reset = 1'b0;

    logic        iv16 = 1'b0, or16 = 1'b0;
    logic [15:0] a16 = '0, b16 = '0;
    logic        ir16, ov16, dz16, busy16;
    logic [15:0] q16, r16;

    logic        iv8 = 1'b0, or8 = 1'b0;
    logic [7:0]  a8 = '0, b8 = '0;
    logic        ir8, ov8, dz8, busy8;
    logic [7:0]  q8, r8;

`ifdef DIV_SIGNED_EN
    logic sg16 = 1'b0, sg8 = 1'b0;
`endif

    logic [63:0] eq16 = '0, er16 = '0, eq8 = '0, er8 = '0;
    logic        ez16 = 1'b0, ez8 = 1'b0;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clock = ~clock;

    div_seq_param #(.WIDTH(16)) dut16 (
        .clock(clock), .reset(reset),
        .in_valid(iv16), .in_ready(ir16), .dividend(a16), .divisor(b16),
`ifdef DIV_SIGNED_EN
        .is_signed(sg16),
`endif
        .out_valid(ov16), .out_ready(or16), .quotient(q16), .remainder(r16),
        .dz(dz16), .busy(busy16)
    );

    div_seq_param #(.WIDTH(8)) dut8 (
        .clock(clock), .reset(reset),
        .in_valid(iv8), .in_ready(ir8), .dividend(a8), .divisor(b8),
`ifdef DIV_SIGNED_EN
        .is_signed(sg8),
`endif
        .out_valid(ov8), .out_ready(or8), .quotient(q8), .remainder(r8),
        .dz(dz8), .busy(busy8)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference arithmetic: plain integer division on masked (or sign-extended) operands.
    task automatic model(input int w, input logic [63:0] a, input logic [63:0] b, input bit sgn,
                         output logic [63:0] q, output logic [63:0] r, output bit z);
        logic [63:0] mask;
        longint      sa, sb;
        mask = (64'd1 << w) - 64'd1;
        a = a & mask;
        b = b & mask;
        if (b == 0) begin
            q = mask; r = a; z = 1'b1;
        end else if (sgn) begin
            sa = $signed(a << (64 - w)) >>> (64 - w);
            sb = $signed(b << (64 - w)) >>> (64 - w);
            q = 64'(sa / sb) & mask;
            r = 64'(sa % sb) & mask;
            z = 1'b0;
        end else begin
            q = a / b; r = a % b; z = 1'b0;
        end
    endtask

    function automatic logic get_ov(int w);   return (w == 16) ? ov16 : ov8;   endfunction
    function automatic logic get_ir(int w);   return (w == 16) ? ir16 : ir8;   endfunction
    function automatic logic get_busy(int w); return (w == 16) ? busy16 : busy8; endfunction
    function automatic logic get_dz(int w);   return (w == 16) ? dz16 : dz8;   endfunction
    function automatic logic [63:0] get_q(int w); return (w == 16) ? 64'(q16) : 64'(q8); endfunction
    function automatic logic [63:0] get_r(int w); return (w == 16) ? 64'(r16) : 64'(r8); endfunction

    task automatic set_in(input int w, input logic v, input logic [63:0] a, input logic [63:0] b);
        if (w == 16) begin iv16 = v; a16 = a[15:0]; b16 = b[15:0]; end
        else         begin iv8  = v; a8  = a[7:0];  b8  = b[7:0];  end
    endtask

    task automatic set_or(input int w, input logic v);
        if (w == 16) or16 = v; else or8 = v;
    endtask

    // One complete transaction: accept, latency count, optional DONE stall, handshake.
    task automatic do_op(input string tag, input int w, input logic [63:0] a, input logic [63:0] b,
                         input bit sgn, input int hold, input bit noise);
        logic [63:0] mq, mr;
        bit          mz;
        int          lat, exp_lat, waited;
        model(w, a, b, sgn, mq, mr, mz);
        if (w == 16) begin eq16 = mq; er16 = mr; ez16 = mz; end
        else         begin eq8  = mq; er8  = mr; ez8  = mz; end
        exp_lat = mz ? 1 : w + 1 + SIGNED_BUILD;
`ifdef DIV_SIGNED_EN
        if (w == 16) sg16 = sgn; else sg8 = sgn;
`endif
        waited = 0;
        while (!get_ir(w) && waited < 100) begin
            @(posedge clock); #1; waited++;
        end
        check({tag, "_ready"}, 64'(get_ir(w)), 64'd1);
        set_in(w, 1'b1, a, b);
        @(posedge clock); #1;
        set_in(w, 1'b0, a, b);
        lat = 1;
        while (!get_ov(w) && lat < 200) begin
            if (noise && lat == 3) set_in(w, 1'b1, ~a, b ^ 64'd1);
            if (noise && lat == 4) set_in(w, 1'b0, a, b);
            @(posedge clock); #1; lat++;
        end
        check({tag, "_latency"}, 64'(lat), 64'(exp_lat));
        repeat (hold) begin
            @(posedge clock); #1;
            check({tag, "_hold_valid"}, 64'(get_ov(w)), 64'd1);
        end
        set_or(w, 1'b1);
        @(posedge clock); #1;
        set_or(w, 1'b0);
        check({tag, "_post_valid"}, 64'(get_ov(w)), 64'd0);
        check({tag, "_post_ready"}, 64'(get_ir(w)), 64'd1);
        check({tag, "_post_q"}, get_q(w), mq);
        check({tag, "_post_r"}, get_r(w), mr);
        check({tag, "_post_dz"}, 64'(get_dz(w)), 64'(mz));
    endtask

    // Compare process: results against the model whenever they are presented, plus busy/ready coherence.
    always @(negedge clock) begin
        if (!reset) begin
            check("busy16_vs_ready", 64'(busy16), 64'(!ir16));
            check("busy8_vs_ready", 64'(busy8), 64'(!ir8));
            if (ov16) begin
                check("cmp16_q", 64'(q16), eq16);
                check("cmp16_r", 64'(r16), er16);
                check("cmp16_dz", 64'(dz16), 64'(ez16));
                check("cmp16_in_ready", 64'(ir16), 64'd0);
            end
            if (ov8) begin
                check("cmp8_q", 64'(q8), eq8);
                check("cmp8_r", 64'(r8), er8);
                check("cmp8_dz", 64'(dz8), 64'(ez8));
                check("cmp8_in_ready", 64'(ir8), 64'd0);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] pq, pr;
        bit          pz;

        model(16, 64'd100, 64'd7, 1'b0, pq, pr, pz);
        check("pin_model_100_7_q", pq, 64'd14);
        check("pin_model_100_7_r", pr, 64'd2);
        model(8, 64'hF9, 64'h02, 1'b1, pq, pr, pz);
        check("pin_model_s8_q", pq, 64'hFD);
        check("pin_model_s8_r", pr, 64'hFF);
        model(8, 64'h80, 64'hFF, 1'b1, pq, pr, pz);
        check("pin_model_minneg_q", pq, 64'h80);
        model(16, 64'h1234, 64'd0, 1'b0, pq, pr, pz);
        check("pin_model_dz_q", pq, 64'hFFFF);

        #2 reset = 1'b1;
        #10;
        check("rst16_in_ready", 64'(ir16), 64'd1);
        check("rst16_out_valid", 64'(ov16), 64'd0);
        check("rst16_busy", 64'(busy16), 64'd0);
        check("rst16_q", 64'(q16), 64'd0);
        check("rst16_r", 64'(r16), 64'd0);
        check("rst16_dz", 64'(dz16), 64'd0);
        check("rst8_in_ready", 64'(ir8), 64'd1);
        check("rst8_busy", 64'(busy8), 64'd0);
        @(posedge clock); #1 reset = 1'b0;

        do_op("u16_100_7", 16, 64'd100, 64'd7, 1'b0, 0, 1'b0);
        check("lit_100_7_q", 64'(q16), 64'd14);
        check("lit_100_7_r", 64'(r16), 64'd2);
        check("lit_100_7_dz", 64'(dz16), 64'd0);
        do_op("u16_dz", 16, 64'h1234, 64'd0, 1'b0, 0, 1'b0);
        check("lit_dz_q", 64'(q16), 64'hFFFF);
        check("lit_dz_r", 64'(r16), 64'h1234);
        check("lit_dz_dz", 64'(dz16), 64'd1);
        do_op("u16_zero_num", 16, 64'd0, 64'd9, 1'b0, 0, 1'b0);
        do_op("u16_max_max", 16, 64'hFFFF, 64'hFFFF, 1'b0, 0, 1'b0);
        do_op("u16_div1", 16, 64'hBEEF, 64'd1, 1'b0, 0, 1'b0);
        do_op("u16_noise", 16, 64'd1234, 64'd5678, 1'b0, 0, 1'b1);
        do_op("u16_big", 16, 64'hFFFF, 64'd256, 1'b0, 0, 1'b0);
        do_op("u16_hold", 16, 64'd1000, 64'd33, 1'b0, 10, 1'b0);
        check("lit_1000_33_q", 64'(q16), 64'd30);
        check("lit_1000_33_r", 64'(r16), 64'd10);

        do_op("u8_255_255", 8, 64'd255, 64'd255, 1'b0, 0, 1'b0);
        check("lit8_255_255_q", 64'(q8), 64'd1);
        check("lit8_255_255_r", 64'(r8), 64'd0);
        do_op("u8_5_9", 8, 64'd5, 64'd9, 1'b0, 0, 1'b0);
        check("lit8_5_9_q", 64'(q8), 64'd0);
        check("lit8_5_9_r", 64'(r8), 64'd5);
        do_op("u8_200_1", 8, 64'd200, 64'd1, 1'b0, 0, 1'b0);
        check("lit8_200_1_q", 64'(q8), 64'd200);
        do_op("u8_dz", 8, 64'd0, 64'd0, 1'b0, 2, 1'b0);
        do_op("u8_17_4", 8, 64'd17, 64'd4, 1'b0, 0, 1'b1);

`ifdef DIV_SIGNED_EN
        do_op("s8_m7_2", 8, 64'hF9, 64'h02, 1'b1, 0, 1'b0);
        check("lit_s8_m7_2_q", 64'(q8), 64'hFD);
        check("lit_s8_m7_2_r", 64'(r8), 64'hFF);
        do_op("s8_minneg", 8, 64'h80, 64'hFF, 1'b1, 0, 1'b0);
        check("lit_s8_minneg_q", 64'(q8), 64'h80);
        check("lit_s8_minneg_r", 64'(r8), 64'h00);
        do_op("s8_dz", 8, 64'h85, 64'h00, 1'b1, 0, 1'b0);
        do_op("s8_7_m2", 8, 64'h07, 64'hFE, 1'b1, 0, 1'b0);
        do_op("s16_neg", 16, 64'h8000, 64'd3, 1'b1, 0, 1'b0);
        do_op("s16_unsigned_mode", 16, 64'h8000, 64'd3, 1'b0, 0, 1'b0);
`endif

        // Abort a 16-bit division in its fifth CALC cycle.
        check("abort_ready", 64'(ir16), 64'd1);
        set_in(16, 1'b1, 64'd40000, 64'd3);
        @(posedge clock); #1;
        set_in(16, 1'b0, 64'd40000, 64'd3);
        repeat (4) @(posedge clock);
        #3 reset = 1'b1;
        #1;
        check("abort_busy", 64'(busy16), 64'd0);
        check("abort_out_valid", 64'(ov16), 64'd0);
        check("abort_in_ready", 64'(ir16), 64'd1);
        check("abort_q", 64'(q16), 64'd0);
        check("abort_r", 64'(r16), 64'd0);
        @(posedge clock); #1 reset = 1'b0;
        do_op("u16_after_abort", 16, 64'd50, 64'd5, 1'b0, 0, 1'b0);
        check("lit_50_5_q", 64'(q16), 64'd10);
        check("lit_50_5_r", 64'(r16), 64'd0);

        repeat (3) @(posedge clock);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
